regfile_mp_sb: RTL and testbench

//  Parametrised multi-port ARM register file with an integrated write-pending scoreboard.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/regfile_mp_sb.sv | 89 ++++++++
 tb/tb_regfile_mp_sb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;

  // When both write-back ports target the same register, the load port wins.
  localparam bit WB_LOAD_WINS = 1'b1;

  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] init_val(input int i);
    return 64'(i);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with saturation, sticky overflow flag
// and per-read-port busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int NUM_RD      = 3,
  parameter int PEND_W      = 2,
  parameter int AW          = aw(NUM_REGS),
  parameter bit MASK_RETIRE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_dest,
  input  logic                 dec0_en,
  input  logic [AW-1:0]        dec0_addr,
  input  logic                 dec1_en,
  input  logic [AW-1:0]        dec1_addr,
  output logic [NUM_RD-1:0]    busy,
  output logic                 pend_ovf
);

  localparam int CNT_MAX = (1 << PEND_W) - 1;

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              ovf_set;

  // Net delta per register in one edge; clamp at both ends and flag the attempt.
  always_comb begin
    ovf_set = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      int sum;
      sum = int'(cnt_q[r]);
      if (issue_en && issue_dest == AW'(r)) sum = sum + 1;
      if (dec0_en && dec0_addr == AW'(r))   sum = sum - 1;
      if (dec1_en && dec1_addr == AW'(r))   sum = sum - 1;
      if (sum > CNT_MAX) begin
        cnt_d[r] = PEND_W'(CNT_MAX);
        ovf_set  = 1'b1;
      end else if (sum < 0) begin
        cnt_d[r] = '0;
        ovf_set  = 1'b1;
      end else begin
        cnt_d[r] = PEND_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      pend_ovf <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      if (ovf_set) pend_ovf <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0] a;
      a       = rd_addr[k*AW +: AW];
      busy[k] = (cnt_q[a] != '0);
      // A write-back retiring the last pending write is forwarded, so the reader need not stall.
      if (MASK_RETIRE && cnt_q[a] == PEND_W'(1) && cnt_d[a] == '0) busy[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write-back ports and a write-pending scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data to the read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 3,
  parameter int PEND_W   = 2,
  localparam int AW      = aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_dest,
  input  logic                     wb0_en,
  input  logic [AW-1:0]            wb0_addr,
  input  logic [DATA_W-1:0]        wb0_data,
  input  logic                     wb1_en,
  input  logic [AW-1:0]            wb1_addr,
  input  logic [DATA_W-1:0]        wb1_data,
  output logic                     wr_conflict,
  output logic                     pend_ovf
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              same_addr;
  logic              wb0_we;
  logic              wb1_we;

  assign same_addr = wb0_en && wb1_en && (wb0_addr == wb1_addr);
  assign wb0_we    = wb0_en && !(same_addr && WB_LOAD_WINS);
  assign wb1_we    = wb1_en && !(same_addr && !WB_LOAD_WINS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(init_val(i));
      wr_conflict <= 1'b0;
    end else begin
      if (wb0_we) regs_q[wb0_addr] <= wb0_data;
      if (wb1_we) regs_q[wb1_addr] <= wb1_data;
      wr_conflict <= same_addr;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      rd_data[k*DATA_W +: DATA_W] = regs_q[a];
`ifdef REGFILE_BYPASS_EN
      if (wb1_en && wb1_addr == a)      rd_data[k*DATA_W +: DATA_W] = wb1_data;
      else if (wb0_en && wb0_addr == a) rd_data[k*DATA_W +: DATA_W] = wb0_data;
`endif
    end
  end

  // Both write-back ports decrement, even when the ALU data itself is dropped.
  regfile_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .NUM_RD      (NUM_RD),
    .PEND_W      (PEND_W),
    .AW          (AW),
    .MASK_RETIRE (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .dec0_en    (wb0_en),
    .dec0_addr  (wb0_addr),
    .dec1_en    (wb1_en),
    .dec1_addr  (wb1_addr),
    .busy       (rd_busy),
    .pend_ovf   (pend_ovf)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table, reset sequence,
// then randomized traffic against a behavioural model.
module tb_regfile_mp_sb;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int NRD = 3;
  localparam int PW  = 2;
  localparam int AW  = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] Z  = 32'd0;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              issue_en;
  logic [AW-1:0]     issue_dest;
  logic              wb0_en;
  logic [AW-1:0]     wb0_addr;
  logic [DW-1:0]     wb0_data;
  logic              wb1_en;
  logic [AW-1:0]     wb1_addr;
  logic [DW-1:0]     wb1_data;
  logic              wr_conflict;
  logic              pend_ovf;

  int checks = 0;
  int errors = 0;

  regfile_mp_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .PEND_W   (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .issue_en    (issue_en),
    .issue_dest  (issue_dest),
    .wb0_en      (wb0_en),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb1_en      (wb1_en),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wr_conflict (wr_conflict),
    .pend_ovf    (pend_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ie;
    logic [3:0]  id;
    logic        w0e;
    logic [3:0]  w0a;
    logic [31:0] w0d;
    logic        w1e;
    logic [3:0]  w1a;
    logic [31:0] w1d;
    logic [3:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  eb;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs [17];

  // Behavioural model: register contents, pending counts, flags.
  logic [31:0] m_mem [NR];
  int          m_cnt [NR];
  bit          m_ovf;
  bit          m_conf;

  task automatic modelReset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i] = 32'(i);
      m_cnt[i] = 0;
    end
    m_ovf  = 1'b0;
    m_conf = 1'b0;
  endtask

  function automatic int netDelta(input int r);
    int d;
    d = 0;
    if (issue_en && int'(issue_dest) == r) d = d + 1;
    if (wb0_en && int'(wb0_addr) == r)     d = d - 1;
    if (wb1_en && int'(wb1_addr) == r)     d = d - 1;
    return d;
  endfunction

  task automatic modelClock();
    int n;
    for (int r = 0; r < NR; r++) begin
      n = m_cnt[r] + netDelta(r);
      if (n > 3)      begin m_cnt[r] = 3; m_ovf = 1'b1; end
      else if (n < 0) begin m_cnt[r] = 0; m_ovf = 1'b1; end
      else            m_cnt[r] = n;
    end
    m_conf = wb0_en && wb1_en && (wb0_addr == wb1_addr);
    if (wb0_en && !m_conf) m_mem[wb0_addr] = wb0_data;
    if (wb1_en)            m_mem[wb1_addr] = wb1_data;
  endtask

  task automatic applyStimulus(input vec_t v);
    issue_en   = v.ie;
    issue_dest = v.id;
    wb0_en     = v.w0e;
    wb0_addr   = v.w0a;
    wb0_data   = v.w0d;
    wb1_en     = v.w1e;
    wb1_addr   = v.w1a;
    wb1_data   = v.w1d;
    rd_addr    = {v.ra2, v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] ed, input logic [2:0] eb,
                             input logic ec, input logic eo);
    checks++;
    if (rd_data !== ed) begin
      errors++;
      $display("[TB] FAIL %s rd_data: got %h expected %h", tag, rd_data, ed);
    end
    checks++;
    if (rd_busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s rd_busy: got %b expected %b", tag, rd_busy, eb);
    end
    checks++;
    if (wr_conflict !== ec) begin
      errors++;
      $display("[TB] FAIL %s wr_conflict: got %b expected %b", tag, wr_conflict, ec);
    end
    checks++;
    if (pend_ovf !== eo) begin
      errors++;
      $display("[TB] FAIL %s pend_ovf: got %b expected %b", tag, pend_ovf, eo);
    end
  endtask

  task automatic clearInputs();
    issue_en = 1'b0; issue_dest = '0;
    wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
  endtask

  initial begin
    logic [95:0] ed;
    logic [2:0]  eb;
    logic [3:0]  a;

    vecs = '{
      '{1'b1,4'd3, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd5,4'd5,4'd5, 32'd5,32'd5,32'd5,               3'b000,1'b0,1'b0},
      '{1'b1,4'd7, 1'b1,4'd3,DB,        1'b0,4'd0,Z,         4'd3,4'd7,4'd0, BYP ? DB : 32'd3,32'd7,32'd0,    {2'b00,!BYP},1'b0,1'b0},
      '{1'b1,4'd7, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd3,4'd7,4'd0, DB,32'd7,32'd0,                  3'b010,1'b0,1'b0},
      '{1'b0,4'd0, 1'b1,4'd7,32'h11,    1'b1,4'd7,32'h22,    4'd3,4'd7,4'd0, DB,BYP ? 32'h22 : 32'd7,32'd0,   3'b010,1'b0,1'b0},
      '{1'b1,4'd4, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd3,4'd7,4'd4, DB,32'h22,32'd4,                 3'b000,1'b1,1'b0},
      '{1'b1,4'd4, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd3,4'd7,4'd4, DB,32'h22,32'd4,                 3'b100,1'b0,1'b0},
      '{1'b0,4'd0, 1'b1,4'd4,32'h44,    1'b0,4'd0,Z,         4'd3,4'd7,4'd4, DB,32'h22,BYP ? 32'h44 : 32'd4,  3'b100,1'b0,1'b0},
      '{1'b0,4'd0, 1'b0,4'd0,Z,         1'b1,4'd4,32'h55,    4'd3,4'd7,4'd4, DB,32'h22,BYP ? 32'h55 : 32'h44, {!BYP,2'b00},1'b0,1'b0},
      '{1'b1,4'd2, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd7,4'd4, 32'd2,32'h22,32'h55,             3'b000,1'b0,1'b0},
      '{1'b1,4'd2, 1'b1,4'd2,32'h66,    1'b0,4'd0,Z,         4'd2,4'd7,4'd4, BYP ? 32'h66 : 32'd2,32'h22,32'h55, 3'b001,1'b0,1'b0},
      '{1'b0,4'd0, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b001,1'b0,1'b0},
      '{1'b1,4'd9, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b001,1'b0,1'b0},
      '{1'b1,4'd9, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b011,1'b0,1'b0},
      '{1'b1,4'd9, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b011,1'b0,1'b0},
      '{1'b1,4'd9, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b011,1'b0,1'b0},
      '{1'b0,4'd0, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b011,1'b0,1'b1},
      '{1'b0,4'd0, 1'b0,4'd0,Z,         1'b0,4'd0,Z,         4'd2,4'd9,4'd4, 32'h66,32'd9,32'h55,             3'b011,1'b0,1'b1}
    };

    // Power-on reset
    rst = 1'b1;
    clearInputs();
    rd_addr = {4'd5, 4'd5, 4'd5};
    #2;
    checkOutput("reset", {32'd5, 32'd5, 32'd5}, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: outputs checked before the edge that applies each row
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), {vecs[i].e2, vecs[i].e1, vecs[i].e0},
                  vecs[i].eb, vecs[i].ec, vecs[i].eo);
      @(posedge clk); #1;
    end

    // Mid-run reset with a write and an issue presented in the same cycle
    issue_en = 1'b1; issue_dest = 4'd5;
    wb0_en = 1'b1; wb0_addr = 4'd5; wb0_data = 32'hAA;
    wb1_en = 1'b1; wb1_addr = 4'd5; wb1_data = 32'hBB;
    rd_addr = {4'd5, 4'd5, 4'd5};
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", {32'd5, 32'd5, 32'd5}, 3'b000, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_hold", {32'd5, 32'd5, 32'd5}, 3'b000, 1'b0, 1'b0);
    clearInputs();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    rd_addr = {4'd7, 4'd9, 4'd5};
    #1 checkOutput("post_rst", {32'd7, 32'd9, 32'd5}, 3'b000, 1'b0, 1'b0);
    modelReset();

    // Randomized traffic against the model, confined to r0..r7 to provoke hazards
    for (int c = 0; c < 400; c++) begin
      issue_en   = 1'($urandom_range(0, 1));
      issue_dest = 4'($urandom_range(0, 7));
      wb0_en     = 1'($urandom_range(0, 1));
      wb0_addr   = 4'($urandom_range(0, 7));
      wb0_data   = $urandom();
      wb1_en     = 1'($urandom_range(0, 1));
      wb1_addr   = 4'($urandom_range(0, 7));
      wb1_data   = $urandom();
      for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = 4'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) begin
        a = rd_addr[k*AW +: AW];
        ed[k*32 +: 32] = m_mem[a];
        eb[k] = (m_cnt[a] != 0);
        if (BYP) begin
          if (wb1_en && wb1_addr == a)      ed[k*32 +: 32] = wb1_data;
          else if (wb0_en && wb0_addr == a) ed[k*32 +: 32] = wb0_data;
          if (m_cnt[a] == 1 && m_cnt[a] + netDelta(int'(a)) <= 0) eb[k] = 1'b0;
        end
      end
      @(negedge clk);
      checkOutput($sformatf("rand%0d", c), ed, eb, m_conf, m_ovf);
      @(posedge clk);
      modelClock();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
